// File: rtl/lc3_mem_subsys_if.sv
// ---------------------------------------------------------------------------
// lc3_mem_subsys_if
// Request/ready bus between the LC-3 datapath (MAR/MDR control) and the
// memory subsystem.
//   cs       master->slave  access request
//   r_w      master->slave  1 = write, 0 = read
//   addr     master->slave  word address
//   data_in  master->slave  write data
//   ready    slave->master  one-cycle access-complete pulse
//   data_out slave->master  read data, valid while ready = 1
// ---------------------------------------------------------------------------
interface lc3_mem_subsys_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  cs;
    logic                  r_w;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output cs, r_w, addr, data_in, input  ready, data_out);
    modport slave  (input  cs, r_w, addr, data_in, output ready, data_out);
endinterface

// File: rtl/lc3_mem_subsys.sv
// ---------------------------------------------------------------------------
// lc3_mem_subsys
// LC-3 memory subsystem: word-addressed RAM plus memory-mapped keyboard,
// display and machine-control registers behind one request/ready handshake,
// with WAIT_STATES extra cycles of latency per access.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   bus (slave)        cs / r_w / addr / data_in / ready / data_out
//   kbd_valid/kbd_char keyboard strobe and character
//   disp_valid/char    display character pending / character
//   disp_ready         display accepts the pending character
//   halt               sticky; set by writing MCR with bit 15 = 0
//
// The RAM has no image preload: it powers up undefined and is initialised
// only by writes. INIT_FILE is kept as a parameter for interface stability.
// ---------------------------------------------------------------------------
module lc3_mem_subsys #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DEPTH       = 65536,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE     = ADDR_WIDTH'(16'hFE00),
    parameter string                 INIT_FILE   = "lc3os.hex"
) (
    input  logic                   clk,
    input  logic                   reset,
    lc3_mem_subsys_if.slave        bus,
    input  logic                   kbd_valid,
    input  logic [7:0]             kbd_char,
    output logic                   disp_valid,
    output logic [7:0]             disp_char,
    input  logic                   disp_ready,
    output logic                   halt
);
    localparam int                    RAM_AW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] KBSR_A  = ADDR_WIDTH'(16'hFE00);
    localparam logic [ADDR_WIDTH-1:0] KBDR_A  = ADDR_WIDTH'(16'hFE02);
    localparam logic [ADDR_WIDTH-1:0] DSR_A   = ADDR_WIDTH'(16'hFE04);
    localparam logic [ADDR_WIDTH-1:0] DDR_A   = ADDR_WIDTH'(16'hFE06);
    localparam logic [ADDR_WIDTH-1:0] MCR_A   = ADDR_WIDTH'(16'hFFFE);
    localparam logic [DATA_WIDTH-1:0] MSB     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  r_w_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Device state. DSR[15] is exactly !disp_valid, so it needs no register.
    logic                  kbsr_q;
    logic [7:0]            kbdr_q;
    logic                  disp_valid_q;
    logic [7:0]            disp_char_q;
    logic [DATA_WIDTH-1:0] mcr_q;
    logic                  halt_q;

    // data_out is assembled from a RAM read register and a device read
    // register, selected by where the last completed read came from.
    logic                  src_ram_q;
    logic [DATA_WIDTH-1:0] ram_rdata_q;
    logic [DATA_WIDTH-1:0] io_rdata_q;
    logic [DATA_WIDTH-1:0] io_rdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) is reserved for combinational blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; pure datapath, so no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.cs) begin
            r_w_q   <= bus.r_w;
            addr_q  <= bus.addr;
            wdata_q <= bus.data_in;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (bus.cs) begin
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: if (cnt_q == '0) state_d = DONE;
                  else             cnt_d   = cnt_q - 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.ready = (state_q == DONE);
    end

    // ---------------- Commit decode ----------------
    // With zero wait states the commit edge is the one that accepts cs, so
    // the request must be taken straight from the bus rather than the latch.
    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  commit, rd_commit, wr_commit;
    logic                  is_io, ram_hit;
    logic [RAM_AW-1:0]     ram_idx;

    always_comb begin
        acc_wr    = (state_q == IDLE) ? bus.r_w     : r_w_q;
        acc_addr  = (state_q == IDLE) ? bus.addr    : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.data_in : wdata_q;
    end

    assign commit    = (state_d == DONE) && (state_q != DONE) && !reset;
    assign rd_commit = commit && !acc_wr;
    assign wr_commit = commit &&  acc_wr;
    assign is_io     = (acc_addr >= IO_BASE);
    assign ram_hit   = !is_io && ({1'b0, acc_addr} < DEPTH_L);
    assign ram_idx   = acc_addr[RAM_AW-1:0];

    always_comb begin
        io_rdata = '0;
        if (is_io) begin
            unique case (acc_addr)
                KBSR_A:  io_rdata = kbsr_q ? MSB : '0;
                KBDR_A:  io_rdata = DATA_WIDTH'(kbdr_q);
                DSR_A:   io_rdata = disp_valid_q ? '0 : MSB;
                DDR_A:   io_rdata = DATA_WIDTH'(disp_char_q);
                MCR_A:   io_rdata = mcr_q;
                default: io_rdata = '0;
            endcase
        end
    end

    // ---------------- RAM ----------------
    // NOTE: the array is deliberately not reset; a reset port on every word
    // would prevent block-RAM inference and reset must not clear memory.
    always_ff @(posedge clk) begin
        if (wr_commit && ram_hit) mem[ram_idx] <= acc_wdata;
        if (rd_commit && ram_hit) ram_rdata_q  <= mem[ram_idx];
    end

    // ---------------- Devices and read select ----------------
    logic kbdr_rd, ddr_wr, mcr_wr;
    assign kbdr_rd = rd_commit && is_io && (acc_addr == KBDR_A);
    assign ddr_wr  = wr_commit && is_io && (acc_addr == DDR_A);
    assign mcr_wr  = wr_commit && is_io && (acc_addr == MCR_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr_q       <= 1'b0;
            kbdr_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_char_q  <= '0;
            mcr_q        <= MSB;
            halt_q       <= 1'b0;
            src_ram_q    <= 1'b0;
            io_rdata_q   <= '0;
        end else begin
            // A KBDR read frees the slot on this same edge, so a coinciding
            // strobe is captured instead of dropped.
            if (kbd_valid && (!kbsr_q || kbdr_rd)) begin
                kbdr_q <= kbd_char;
                kbsr_q <= 1'b1;
            end else if (kbdr_rd) begin
                kbsr_q <= 1'b0;
            end
            // A DDR write is only taken while the display is idle.
            if (ddr_wr && !disp_valid_q) begin
                disp_char_q  <= acc_wdata[7:0];
                disp_valid_q <= 1'b1;
            end else if (disp_valid_q && disp_ready) begin
                disp_valid_q <= 1'b0;
            end
            if (mcr_wr) begin
                mcr_q <= acc_wdata;
                if (!acc_wdata[DATA_WIDTH-1]) halt_q <= 1'b1;
            end
            if (rd_commit) begin
                src_ram_q  <= ram_hit;
                io_rdata_q <= io_rdata;
            end
        end
    end

    assign bus.data_out = src_ram_q ? ram_rdata_q : io_rdata_q;
    assign disp_valid   = disp_valid_q;
    assign disp_char    = disp_char_q;
    assign halt         = halt_q;
endmodule

// File: tb/tb_lc3_mem_subsys.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_subsys
// Two instances: u0 (WAIT_STATES=0, full depth) and u3 (WAIT_STATES=3,
// DEPTH=16384). RAM contents are tracked in associative-array models; device
// behaviour is checked against directed expectations.
// ---------------------------------------------------------------------------
module tb_lc3_mem_subsys;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3_mem_subsys_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus0 ();
    lc3_mem_subsys_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus3 ();

    logic       kbd_valid, disp_ready, disp_valid, halt;
    logic [7:0] kbd_char, disp_char;
    logic       kbd_valid3, disp_ready3, disp_valid3, halt3;
    logic [7:0] kbd_char3, disp_char3;

    lc3_mem_subsys #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .kbd_valid(kbd_valid), .kbd_char(kbd_char),
        .disp_valid(disp_valid), .disp_char(disp_char),
        .disp_ready(disp_ready), .halt(halt)
    );

    lc3_mem_subsys #(.WAIT_STATES(3), .DEPTH(16384)) u3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .kbd_valid(kbd_valid3), .kbd_char(kbd_char3),
        .disp_valid(disp_valid3), .disp_char(disp_char3),
        .disp_ready(disp_ready3), .halt(halt3)
    );

    int vectors, miscompares;
    logic [15:0] mem0 [logic [15:0]];
    logic [15:0] mem3 [logic [15:0]];
    logic [15:0] last_rd [2];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Address is backed by RAM in the selected instance.
    function automatic bit ram_ok(input bit sel, input logic [15:0] a);
        return (a < 16'hFE00) && (!sel || a < 16'h4000);
    endfunction

    function automatic bit known(input bit sel, input logic [15:0] a);
        return sel ? mem3.exists(a) : mem0.exists(a);
    endfunction

    function automatic logic [15:0] ram_exp(input bit sel, input logic [15:0] a);
        if (!ram_ok(sel, a)) return 16'h0000;
        return sel ? mem3[a] : mem0[a];
    endfunction

    // One access: cs for one cycle, then wait (bounded) for ready.
    task automatic acc(input bit sel, input bit wr, input logic [15:0] a,
                       input logic [15:0] d, input bit kv, input logic [7:0] kc,
                       output logic [15:0] rd, output int lat);
        @(negedge clk);
        if (sel) begin
            bus3.cs = 1'b1; bus3.r_w = wr; bus3.addr = a; bus3.data_in = d;
        end else begin
            bus0.cs = 1'b1; bus0.r_w = wr; bus0.addr = a; bus0.data_in = d;
            kbd_valid = kv; kbd_char = kc;
        end
        lat = 0;
        rd  = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            bus0.cs = 1'b0; bus3.cs = 1'b0; kbd_valid = 1'b0;
            if ((sel ? bus3.ready : bus0.ready) === 1'b1) begin
                rd = sel ? bus3.data_out : bus0.data_out;
                break;
            end
        end
    endtask

    task automatic write(input bit sel, input logic [15:0] a, input logic [15:0] d,
                         input string tag);
        logic [15:0] rd;
        int lat;
        acc(sel, 1'b1, a, d, 1'b0, 8'h00, rd, lat);
        check({tag, "_lat"}, 16'(lat), sel ? 16'd4 : 16'd1);
        check({tag, "_hold"}, rd, last_rd[sel]);
        if (ram_ok(sel, a)) begin
            if (sel) mem3[a] = d;
            else     mem0[a] = d;
        end
    endtask

    task automatic read(input bit sel, input logic [15:0] a, input logic [15:0] exp,
                        input string tag, input bit kv = 1'b0, input logic [7:0] kc = 8'h00);
        logic [15:0] rd;
        int lat;
        acc(sel, 1'b0, a, 16'h0000, kv, kc, rd, lat);
        check({tag, "_lat"}, 16'(lat), sel ? 16'd4 : 16'd1);
        check(tag, rd, exp);
        last_rd[sel] = exp;
    endtask

    task automatic kbd_pulse(input logic [7:0] c);
        @(negedge clk);
        kbd_valid = 1'b1; kbd_char = c;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] a, d;
        bit          sel;
        int          r;
        vectors = 0; miscompares = 0;
        bus0.cs = 0; bus0.r_w = 0; bus0.addr = 0; bus0.data_in = 0;
        bus3.cs = 0; bus3.r_w = 0; bus3.addr = 0; bus3.data_in = 0;
        kbd_valid = 0; kbd_char = 0; disp_ready = 0;
        kbd_valid3 = 0; kbd_char3 = 0; disp_ready3 = 1;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready0", 16'(bus0.ready), 16'h0);
        check("rst_ready3", 16'(bus3.ready), 16'h0);
        check("rst_dout0", bus0.data_out, 16'h0);
        check("rst_dout3", bus3.data_out, 16'h0);
        check("rst_dvalid", 16'(disp_valid), 16'h0);
        check("rst_dchar", 16'(disp_char), 16'h0);
        check("rst_halt", 16'(halt), 16'h0);
        reset = 1'b0;
        read(0, 16'hFE00, 16'h0000, "rst_kbsr");
        read(0, 16'hFE02, 16'h0000, "rst_kbdr");
        read(0, 16'hFE04, 16'h8000, "rst_dsr");
        read(0, 16'hFFFE, 16'h8000, "rst_mcr");

        // Zero wait-state RAM write then read
        write(0, 16'h3000, 16'h1234, "w3000");
        read(0, 16'h3000, ram_exp(0, 16'h3000), "r3000");

        // Keyboard: second strobe dropped while a char is pending
        kbd_pulse(8'h41);
        kbd_pulse(8'h42);
        read(0, 16'hFE00, 16'h8000, "kbsr_full");
        read(0, 16'hFE02, 16'h0041, "kbdr_41");
        read(0, 16'hFE00, 16'h0000, "kbsr_clr");
        read(0, 16'hFE02, 16'h0041, "kbdr_42drop");
        // Strobe coinciding with the KBDR read commit
        kbd_pulse(8'h43);
        read(0, 16'hFE02, 16'h0043, "kbdr_43", 1'b1, 8'h44);
        read(0, 16'hFE00, 16'h8000, "kbsr_stay");
        read(0, 16'hFE02, 16'h0044, "kbdr_44");
        read(0, 16'hFE00, 16'h0000, "kbsr_clr2");

        // Display
        write(0, 16'hFE06, 16'h0048, "ddr_48");
        check("dvalid_48", 16'(disp_valid), 16'h1);
        check("dchar_48", 16'(disp_char), 16'h0048);
        read(0, 16'hFE04, 16'h0000, "dsr_busy");
        write(0, 16'hFE06, 16'h0049, "ddr_49");
        check("dchar_49drop", 16'(disp_char), 16'h0048);
        read(0, 16'hFE06, 16'h0048, "ddr_rd");
        @(negedge clk); disp_ready = 1'b1;
        @(negedge clk);
        check("dvalid_clr", 16'(disp_valid), 16'h0);
        read(0, 16'hFE04, 16'h8000, "dsr_idle");
        disp_ready = 1'b0;
        write(0, 16'hFE06, 16'h0050, "ddr_50");
        check("dvalid_50", 16'(disp_valid), 16'h1);
        // DDR write commit on the same edge as the handshake: dropped
        @(negedge clk);
        bus0.cs = 1; bus0.r_w = 1; bus0.addr = 16'hFE06; bus0.data_in = 16'h0051;
        disp_ready = 1'b1;
        @(negedge clk);
        bus0.cs = 0;
        check("ddr_51_ready", 16'(bus0.ready), 16'h1);
        check("dvalid_51", 16'(disp_valid), 16'h0);
        check("dchar_51drop", 16'(disp_char), 16'h0050);
        disp_ready = 1'b0;
        read(0, 16'hFE04, 16'h8000, "dsr_idle2");

        // Unmapped window
        write(0, 16'hFE10, 16'hABCD, "w_fe10");
        read(0, 16'hFE10, 16'h0000, "r_fe10");

        // Halt is sticky
        write(0, 16'hFFFE, 16'h0000, "mcr_w0");
        check("halt_set", 16'(halt), 16'h1);
        read(0, 16'hFFFE, 16'h0000, "mcr_r0");
        write(0, 16'hFFFE, 16'h8000, "mcr_w8");
        check("halt_sticky", 16'(halt), 16'h1);

        // Three wait states, cs held high: pulses at cycles 4 and 9
        write(1, 16'h3000, 16'hBEEF, "u3_w3000");
        @(negedge clk);
        bus3.cs = 1; bus3.r_w = 0; bus3.addr = 16'h3000;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("u3_ready_c%0d", c), 16'(bus3.ready), 16'((c == 4) || (c == 9)));
            if (c == 4) check("u3_r3000", bus3.data_out, 16'hBEEF);
        end
        bus3.cs = 0;
        last_rd[1] = 16'hBEEF;

        // Beyond DEPTH on u3
        write(1, 16'h5000, 16'h1357, "u3_w5000");
        read(1, 16'h5000, 16'h0000, "u3_r5000");

        // Reset in the middle of a WAIT_STATES=3 write
        write(1, 16'h3001, 16'h1111, "u3_w3001");
        @(negedge clk);
        bus3.cs = 1; bus3.r_w = 1; bus3.addr = 16'h3001; bus3.data_in = 16'h2222;
        @(negedge clk);
        bus3.cs = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_mid_ready", 16'(bus3.ready), 16'h0);
        end
        reset = 1'b0;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_rst_ready", 16'(bus3.ready), 16'h0);
        end
        check("rst_halt_clr", 16'(halt), 16'h0);
        read(0, 16'hFFFE, 16'h8000, "rst_mcr2");
        read(1, 16'h3001, ram_exp(1, 16'h3001), "u3_r3001");
        read(0, 16'h3000, ram_exp(0, 16'h3000), "ram_kept");

        // Randomised RAM traffic on both instances
        for (int n = 0; n < 160; n++) begin
            sel = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 9));
            a   = 16'h3000 + 16'($urandom_range(0, 31));
            d   = 16'($urandom);
            if (r == 0) a = 16'h4000 + 16'($urandom_range(0, 31));
            if (r == 9) begin
                read(sel, 16'hFE10 + 16'($urandom_range(0, 7) * 2), 16'h0000, "rnd_win");
            end else if (r >= 5 && (!ram_ok(sel, a) || known(sel, a))) begin
                read(sel, a, ram_exp(sel, a), $sformatf("rnd_r%0d_%h", sel, a));
            end else begin
                write(sel, a, d, $sformatf("rnd_w%0d_%h", sel, a));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lc3_mem_subsys.md
Name: lc3_mem_subsys

Overview:
Parametrised LC-3 memory subsystem: word-addressed RAM array plus memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR) behind one request/ready handshake.
Configurable wait-state latency. Keyboard and display are real handshake ports; no simulation-only I/O side effects.
Sits between the LC-3 datapath memory interface (MAR/MDR control) and the external keyboard/display models.

Parameters:
DATA_WIDTH, 16, word width of RAM and data ports
ADDR_WIDTH, 16, address width
DEPTH, 65536, number of RAM words; RAM addresses >= DEPTH read 0, writes ignored
WAIT_STATES, 0, extra cycles inserted before ready (0..15)
IO_BASE, 16'hFE00, start of device window; addresses >= IO_BASE never reach RAM
INIT_FILE, "lc3os.hex", hex image path (used only with the optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
cs  input  1  access request
r_w  input  1  1 = write, 0 = read
addr  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
ready  output  1  one-cycle access-complete pulse
data_out  output  DATA_WIDTH  read data, valid while ready=1
kbd_valid  input  1  keyboard strobes a character
kbd_char  input  8  keyboard character
disp_valid  output  1  display character pending
disp_char  output  8  display character
disp_ready  input  1  display accepts character when disp_valid=1
halt  output  1  machine halted (MCR[15] cleared)

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high, named reset.
- Reset values: ready=0, data_out=0, disp_valid=0, disp_char=0, halt=0, KBSR[15]=0, KBDR=0, DSR[15]=1, MCR=16'h8000, FSM=IDLE. RAM is not reset.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if cs=1, latch addr/r_w/data_in. Go to WAIT if WAIT_STATES>0, else DONE.
  - WAIT: count down WAIT_STATES cycles, then go to DONE.
  - DONE: ready=1 for exactly one cycle, then IDLE.
  - cs is ignored outside IDLE.
- Latency: cs high in IDLE at cycle 0 -> ready high in cycle 1+WAIT_STATES.
- Back-to-back throughput: one access per 2+WAIT_STATES cycles.
- Commit point: writes and device side effects (KBDR clear, DDR launch, MCR update) happen on the edge entering DONE.
- Read data is registered on that same edge; data_out holds its value until the next read completes.
- Device window (IO_BASE and above), upper bits read 0:
  - FE00 KBSR: bit15 = character available. Read-only.
  - FE02 KBDR: read returns {8'h00, char} and clears KBSR[15]. Read-only.
  - FE04 DSR: bit15 = display idle. Read-only.
  - FE06 DDR: write latches data_in[7:0] into disp_char, sets disp_valid=1, clears DSR[15]. A write while DSR[15]=0 is dropped (disp_char unchanged). Reads return the last disp_char.
  - FFFE MCR: read/write full word. A write with bit15=0 sets halt=1; halt is sticky until reset.
  - Any other window address reads 0; writes are ignored.
- Keyboard capture: kbd_valid with KBSR[15]=0 latches kbd_char into KBDR and sets KBSR[15]. kbd_valid with KBSR[15]=1 is dropped (no overwrite).
- Simultaneous KBDR read commit and kbd_valid: read returns the old char; the new char is latched and KBSR[15] stays 1.
- Display handshake: while disp_valid=1, a cycle with disp_ready=1 clears disp_valid and sets DSR[15] on the next edge. disp_char holds stable while disp_valid=1.
- Simultaneous disp_ready completion and DDR write commit: the write is dropped, because DSR[15] is still 0 at the commit edge.
- Reset mid-access: FSM returns to IDLE and ready=0. An access not yet at its commit edge has no effect.
- ready is never asserted without a preceding accepted cs.

Optional Feature:
LC3_MEM_INIT_EN
- Defined: RAM preloaded at time zero from INIT_FILE via $readmemh. Reset does not reload it.
- Undefined: no preload. RAM powers up X and is not initialisable except by writes.

Test Plan:
- WAIT_STATES=0: write 16'h1234 @ 16'h3000, then read @ 16'h3000 -> ready one cycle after each cs; read data_out=16'h1234.
- WAIT_STATES=3: read @ 16'h3000 with cs held high -> ready exactly in cycle 4; single pulse; no second access until FSM back in IDLE.
- Keyboard: kbd_valid with 8'h41, then kbd_valid with 8'h42 before any read.
  - KBSR reads 16'h8000; KBDR reads 16'h0041; KBSR then reads 0; 8'h42 dropped.
  - Repeat with kbd_valid coinciding with the KBDR commit -> KBSR stays 16'h8000.
- Display: write DDR 16'h0048 with disp_ready=0 -> disp_valid=1, disp_char=8'h48, DSR=0.
  - A second DDR write of 8'h49 is dropped.
  - Raise disp_ready -> disp_valid=0 next edge; DSR reads 16'h8000.
- Halt/reset: write MCR 16'h0000 -> halt=1 and MCR reads 0.
  - Assert reset during a WAIT_STATES=3 write to 16'h3001 -> ready stays 0, halt=0, MCR=16'h8000, RAM[3001] unchanged.
